// File: rtl/outrow.sv
// Bottom-edge sink for the core array: accepts one value per handshake on each
// down channel, checks it in order against a per-column expected stream, and reports progress.
module outrow #(
  parameter int COLS  = 4,
  parameter int DEPTH = 64,
  parameter int WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COLS-1:0]         write,
  input  logic [WIDTH-1:0]        in        [0:COLS-1],
  output logic [COLS-1:0]         wready,
  input  logic [5:0]              expLength [0:COLS-1],
  input  logic signed [WIDTH-1:0] expData   [0:COLS*DEPTH-1],
  output logic [6:0]              count     [0:COLS-1],
  output logic [7:0]              errors    [0:COLS-1],
  output logic [WIDTH-1:0]        last      [0:COLS-1],
  output logic                    done
);

  // state | meaning
  // IDLE  | ready to capture the next value (unless the column is full)
  // ACK   | value captured, wready high for this single cycle
  // WAIT  | transfer complete, waiting for write to drop
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  localparam int         IDX_W   = (COLS * DEPTH > 1) ? $clog2(COLS * DEPTH) : 1;
  localparam logic [6:0] CNT_MAX = 7'(DEPTH);

  state_t           state_q  [0:COLS-1];
  state_t           state_d  [0:COLS-1];
  logic [6:0]       count_q  [0:COLS-1];
  logic [6:0]       count_d  [0:COLS-1];
  logic [7:0]       errors_q [0:COLS-1];
  logic [7:0]       errors_d [0:COLS-1];
  logic [WIDTH-1:0] last_q   [0:COLS-1];
  logic [WIDTH-1:0] last_d   [0:COLS-1];
  logic [IDX_W-1:0] idx;
  logic             miss;

  always_comb begin
    idx  = '0;
    miss = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      state_d[c]  = state_q[c];
      count_d[c]  = count_q[c];
      errors_d[c] = errors_q[c];
      last_d[c]   = last_q[c];
      case (state_q[c])
        IDLE: begin
          // A full column never acknowledges; the producer simply stalls.
          if (write[c] && (count_q[c] < CNT_MAX)) begin
            state_d[c] = ACK;
            count_d[c] = count_q[c] + 7'd1;
            last_d[c]  = in[c];
            idx        = IDX_W'(c * DEPTH) + IDX_W'(count_q[c]);
            if (count_q[c] >= {1'b0, expLength[c]}) miss = 1'b1;
            else                                    miss = (in[c] != expData[idx]);
            if (miss && (errors_q[c] != 8'hFF)) errors_d[c] = errors_q[c] + 8'd1;
          end
        end
        ACK:     state_d[c] = WAIT;
        WAIT:    if (!write[c]) state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        state_q[c]  <= IDLE;
        count_q[c]  <= '0;
        errors_q[c] <= '0;
        last_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        state_q[c]  <= state_d[c];
        count_q[c]  <= count_d[c];
        errors_q[c] <= errors_d[c];
        last_q[c]   <= last_d[c];
      end
    end
  end

  always_comb begin
    wready = '0;
    done   = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      wready[c] = (state_q[c] == ACK);
      if (count_q[c] < {1'b0, expLength[c]}) done = 1'b0;
    end
  end

  assign count  = count_q;
  assign errors = errors_q;
  assign last   = last_q;

endmodule
